// File: rtl/seq_det_rr_scheduler_if.sv
// Bundle between the per-channel serial bit sources and the shared
// "1010" detect engine: request/data/clear inward, grant and match
// reporting outward.
interface seq_det_rr_scheduler_if #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH),
  parameter int CNT_W  = 16
);
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] din;
  logic [NUM_CH-1:0] clr;
  logic [NUM_CH-1:0] gnt;
  logic              match_valid;
  logic [CH_W-1:0]   match_ch;
  logic [CNT_W-1:0]  match_count;

  // Channel side: presents bits, observes grants and matches.
  modport master (
    output req, din, clr,
    input  gnt, match_valid, match_ch, match_count
  );

  // Engine side.
  modport slave (
    input  req, din, clr,
    output gnt, match_valid, match_ch, match_count
  );
endinterface

// File: rtl/seq_det_rr_scheduler.sv
// One overlapping "1010" detector time-shared by NUM_CH bit-serial
// channels. A round-robin arbiter picks one requester per cycle; each
// channel keeps its own 2-bit detector context so streams never mix.
module seq_det_rr_scheduler #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH),
  parameter int CNT_W  = 16
) (
  input logic                  clk,
  input logic                  resetn,
  seq_det_rr_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    S0   = 2'd0,
    S1   = 2'd1,
    S10  = 2'd2,
    S101 = 2'd3
  } state_t;

  function automatic state_t next_state(state_t s, logic b);
    case (s)
      S0:      next_state = b ? S1   : S0;
      S1:      next_state = b ? S1   : S10;
      S10:     next_state = b ? S101 : S0;
      default: next_state = b ? S1   : S10;
    endcase
  endfunction

  // Counter holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + 1'b1;
  endfunction

  // Channel index reached k steps after p, wrapping at NUM_CH.
  function automatic logic [CH_W-1:0] wrap_idx(logic [CH_W-1:0] p, int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_CH) s = s - NUM_CH;
    wrap_idx = CH_W'(s);
  endfunction

  state_t            ctx_p1 [NUM_CH];
  logic [CH_W-1:0]   ptr_p1;

  logic [NUM_CH-1:0] gnt_p0;
  logic [CH_W-1:0]   gnt_idx_p0;
  logic              gnt_vld_p0;
  logic              hit_p0;

  logic              vld_p1;
  logic [CH_W-1:0]   ch_p1;
  logic [CNT_W-1:0]  cnt_p1;

  // Stage p0: pick the first requester at or after ptr (combinational grant).
  always_comb begin
    gnt_p0     = '0;
    gnt_idx_p0 = '0;
    gnt_vld_p0 = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!gnt_vld_p0 && bus.req[wrap_idx(ptr_p1, k)]) begin
        gnt_p0[wrap_idx(ptr_p1, k)] = 1'b1;
        gnt_idx_p0                  = wrap_idx(ptr_p1, k);
        gnt_vld_p0                  = 1'b1;
      end
    end
  end

  // A granted 0 completes the pattern from S101 unless a clear discards the bit.
  assign hit_p0 = gnt_vld_p0 && !bus.clr[gnt_idx_p0] &&
                  (ctx_p1[gnt_idx_p0] == S101) && !bus.din[gnt_idx_p0];

  // Stage p1: advance pointer and contexts, register the match report.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ptr_p1 <= '0;
      for (int i = 0; i < NUM_CH; i++) ctx_p1[i] <= S0;
      vld_p1 <= 1'b0;
      ch_p1  <= '0;
      cnt_p1 <= '0;
    end else begin
      if (gnt_vld_p0)
        ptr_p1 <= (gnt_idx_p0 == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx_p0 + 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.clr[i])
          ctx_p1[i] <= S0;
        else if (gnt_p0[i])
          ctx_p1[i] <= next_state(ctx_p1[i], bus.din[i]);
      end
      vld_p1 <= hit_p0;
      if (hit_p0) begin
        ch_p1  <= gnt_idx_p0;
        cnt_p1 <= sat_inc(cnt_p1);
      end
    end
  end

  assign bus.gnt         = gnt_p0;
  assign bus.match_valid = vld_p1;
  assign bus.match_ch    = ch_p1;
  assign bus.match_count = cnt_p1;

endmodule

// File: tb/tb_seq_det_rr_scheduler.sv
// Directed bench for seq_det_rr_scheduler (NUM_CH=4, CNT_W=3).
// The driver checks grants and queues expected matches; a negedge monitor
// pops the queue and checks match_valid / match_ch / match_count.
module tb_seq_det_rr_scheduler;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int CNT_W  = 3;
  localparam int CNT_MAX = 7;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  seq_det_rr_scheduler_if #(.NUM_CH(NUM_CH), .CH_W(CH_W), .CNT_W(CNT_W)) bus ();

  seq_det_rr_scheduler #(.NUM_CH(NUM_CH), .CH_W(CH_W), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    int cyc;
    int ch;
    int cnt;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   exp_cnt = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // One cycle of stimulus; checks the grant and queues an expected match.
  task automatic tick(input logic [3:0] r, input logic [3:0] d, input logic [3:0] c,
                      input logic [3:0] eg, input bit em, input int ech);
    @(posedge clk);
    #1;
    bus.req = r;
    bus.din = d;
    bus.clr = c;
    #2;
    check("gnt", int'(bus.gnt), int'(eg));
    if (em) begin
      exp_cnt = (exp_cnt == CNT_MAX) ? CNT_MAX : exp_cnt + 1;
      q.push_back('{cyc + 1, ech, exp_cnt});
    end
  endtask

  // One reset cycle with the given inputs applied, then post-reset checks.
  task automatic do_reset(input logic [3:0] r, input logic [3:0] d);
    @(posedge clk);
    #1;
    resetn  = 1'b0;
    bus.req = r;
    bus.din = d;
    bus.clr = '0;
    #2;
    check("gnt_in_reset", int'(bus.gnt), int'(r & (~r + 4'd1)));
    @(posedge clk);
    #1;
    resetn  = 1'b1;
    bus.req = '0;
    bus.din = '0;
    exp_cnt = 0;
    q.delete();
    check("rst_match_valid", int'(bus.match_valid), 0);
    check("rst_match_ch", int'(bus.match_ch), 0);
    check("rst_match_count", int'(bus.match_count), 0);
  endtask

  // Monitor: compare the DUT's match report against the scoreboard queue.
  always @(negedge clk) begin
    if (mon_en) begin
      bit ev;
      ev = (q.size() > 0) && (q[0].cyc == cyc);
      check("match_valid", int'(bus.match_valid), int'(ev));
      if (ev) begin
        if (bus.match_valid) begin
          check("match_ch", int'(bus.match_ch), q[0].ch);
          check("match_count", int'(bus.match_count), q[0].cnt);
        end
        void'(q.pop_front());
      end
    end
  end

  initial begin
    bus.req = '0;
    bus.din = '0;
    bus.clr = '0;
    do_reset(4'b0000, 4'b0000);
    mon_en = 1'b1;

    // Single channel 1,0,1,0.
    for (int i = 0; i < 4; i++)
      tick(4'b0001, (i % 2 == 0) ? 4'b0001 : 4'b0000, 4'b0000, 4'b0001, i == 3, 0);
    tick(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0);
    tick(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0);

    // Overlap on ch2: matches after bits 4, 6, 8.
    do_reset(4'b0000, 4'b0000);
    for (int i = 0; i < 8; i++)
      tick(4'b0100, (i % 2 == 0) ? 4'b0100 : 4'b0000, 4'b0000, 4'b0100,
           (i >= 3) && (i % 2 == 1), 2);
    tick(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0);

    // Round-robin interleave, all four channels fed 1,0,1,0.
    do_reset(4'b0000, 4'b0000);
    for (int k = 0; k < 4; k++)
      for (int ch = 0; ch < 4; ch++)
        tick(4'b1111, (k % 2 == 0) ? 4'b1111 : 4'b0000, 4'b0000, 4'(1 << ch), k == 3, ch);

    // Skip and wrap: ch1/ch3 alternate, then ch3 alone back-to-back.
    tick(4'b1010, 4'b0000, 4'b0000, 4'b0010, 1'b0, 0);
    tick(4'b1010, 4'b0000, 4'b0000, 4'b1000, 1'b0, 0);
    tick(4'b1010, 4'b0000, 4'b0000, 4'b0010, 1'b0, 0);
    tick(4'b1010, 4'b0000, 4'b0000, 4'b1000, 1'b0, 0);
    tick(4'b1000, 4'b0000, 4'b0000, 4'b1000, 1'b0, 0);
    tick(4'b1000, 4'b0000, 4'b0000, 4'b1000, 1'b0, 0);
    tick(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0);

    // Clear collision on ch1 in S101, then a fresh full pattern.
    do_reset(4'b0000, 4'b0000);
    tick(4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b0, 1);
    tick(4'b0010, 4'b0000, 4'b0000, 4'b0010, 1'b0, 1);
    tick(4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b0, 1);
    tick(4'b0010, 4'b0000, 4'b0010, 4'b0010, 1'b0, 1);
    tick(4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b0, 1);
    tick(4'b0010, 4'b0000, 4'b0000, 4'b0010, 1'b0, 1);
    tick(4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b0, 1);
    tick(4'b0010, 4'b0000, 4'b0000, 4'b0010, 1'b1, 1);
    tick(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0);

    // Saturation: nine matches on ch2, count stops at 7.
    do_reset(4'b0000, 4'b0000);
    for (int i = 0; i < 20; i++)
      tick(4'b0100, (i % 2 == 0) ? 4'b0100 : 4'b0000, 4'b0000, 4'b0100,
           (i >= 3) && (i % 2 == 1), 2);
    // Leave ch2 in S101 with ptr=3, then reset mid-stream.
    tick(4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b0, 0);
    do_reset(4'b0100, 4'b0000);
    tick(4'b1001, 4'b0000, 4'b0000, 4'b0001, 1'b0, 0);
    tick(4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b0, 2);
    for (int i = 0; i < 4; i++)
      tick(4'b0100, (i % 2 == 0) ? 4'b0100 : 4'b0000, 4'b0000, 4'b0100, i == 3, 2);
    tick(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0);
    tick(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0);

    check("queue_drained", q.size(), 0);
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
